// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared bus widths, lane types and the byte-lane merge helper
package data_sram_responder_pkg;
    localparam int SRAM_ADDR_WD = 32;
    localparam int SRAM_DATA_WD = 32;
    localparam int SRAM_WEN_WD = 4;
    typedef logic [SRAM_WEN_WD-1:0] be_t;
    typedef logic [SRAM_DATA_WD-1:0] word_t;
    typedef logic [SRAM_ADDR_WD-1:0] addr_t;
    function automatic word_t merge_bytes(word_t base, word_t upd, be_t be);
        word_t r;
        for (int i = 0; i < SRAM_WEN_WD; i++) r[8*i +: 8] = be[i] ? upd[8*i +: 8] : base[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: SRAM-like request/response bus between core and memory
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;
    logic en;
    be_t wen;
    addr_t addr;
    word_t wdata;
    word_t rdata;
    modport master(output en, wen, addr, wdata, input rdata);
    modport slave(input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_byte_array.sv
// sram_byte_array: block-RAM-style storage, synchronous read, byte-enabled read-before-write
module sram_byte_array import data_sram_responder_pkg::*; #(
    parameter int ADDR_W = 14
) (
    input logic clk,
    input logic re,
    input logic [ADDR_W-1:0] raddr,
    output word_t q,
    input logic we,
    input logic [ADDR_W-1:0] waddr,
    input be_t be,
    input word_t wdata
);
    word_t mem [0:(1<<ADDR_W)-1];
    always_ff @(posedge clk) begin
        if (re) q <= mem[raddr];
        for (int i = 0; i < SRAM_WEN_WD; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: one-cycle-latency SRAM responder with a posted write and store-to-load forwarding
module data_sram_responder import data_sram_responder_pkg::*; #(
    parameter int ADDR_W = 14,
    parameter addr_t BASE_ADDR = 32'h0000_0000,
    parameter word_t RDATA_OOR = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    data_sram_responder_if.slave sram,
    output logic err_o,
    output addr_t err_addr_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);
    logic [ADDR_W-1:0] idx, pend_idx;
    logic in_range, rd, wr, pend_valid, rd_valid, rd_oor;
    be_t pend_be, fwd_be;
    word_t pend_data, fwd_data, q;
    logic unused_lsb;
    assign unused_lsb = ^sram.addr[1:0];
    assign idx = sram.addr[ADDR_W+1:2];
    assign in_range = sram.addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    assign rd = sram.en && sram.wen == '0;
    assign wr = sram.en && sram.wen != '0 && in_range;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_idx <= '0;
            pend_be <= '0;
            pend_data <= '0;
            rd_valid <= 1'b0;
            rd_oor <= 1'b0;
            fwd_be <= '0;
            fwd_data <= '0;
            err_o <= 1'b0;
            err_addr_o <= '0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            pend_valid <= wr;
            if (wr) begin
                pend_idx <= idx;
                pend_be <= sram.wen;
                pend_data <= sram.wdata;
            end
            // The array returns pre-commit data, so capture the pending lanes that must override it
            if (rd) begin
                rd_valid <= 1'b1;
                rd_oor <= !in_range;
                fwd_be <= (pend_valid && pend_idx == idx) ? pend_be : '0;
                fwd_data <= pend_data;
            end
            if (sram.en && !in_range) begin
                err_o <= 1'b1;
                if (!err_o) err_addr_o <= sram.addr;
            end
            if (rd && in_range) rd_cnt_o <= rd_cnt_o + 32'd1;
            if (wr) wr_cnt_o <= wr_cnt_o + 32'd1;
        end
    end
    sram_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk(clk),
        .re(rd && in_range),
        .raddr(idx),
        .q(q),
        .we(pend_valid),
        .waddr(pend_idx),
        .be(pend_be),
        .wdata(pend_data)
    );
    // q and the forward registers only change on reads, so the merged output holds between reads
    assign sram.rdata = !rd_valid ? '0 : rd_oor ? RDATA_OOR : merge_bytes(q, fwd_data, fwd_be);
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: vector table, reset/wrap sequences and random traffic against a program-order memory model
module tb_data_sram_responder;
    localparam logic [31:0] OOR_VAL = 32'h0000_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_o;
    logic [31:0] err_addr_o, rd_cnt_o, wr_cnt_o;
    data_sram_responder_if sram();
    data_sram_responder dut (
        .clk(clk),
        .rst(rst),
        .sram(sram),
        .err_o(err_o),
        .err_addr_o(err_addr_o),
        .rd_cnt_o(rd_cnt_o),
        .wr_cnt_o(wr_cnt_o)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic [3:0] wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[$];

    int total = 0;
    int bad = 0;
    logic [31:0] mem [int];
    logic [3:0] kn [int];
    logic [31:0] m_rdata, m_mask, m_err_addr, m_rd, m_wr;
    logic m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp, logic [31:0] mask = 32'hFFFF_FFFF);
        total++;
        if (((act ^ exp) & mask) != 32'h0) begin
            bad++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    // Memory as seen in program order: every accepted write is visible to the next read
    task automatic model(logic en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wdata);
        int idx;
        logic [31:0] w;
        logic [3:0] k;
        idx = int'(addr[15:2]);
        if (!en) return;
        if (addr[31:16] != 16'h0) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
            if (wen == 4'h0) begin
                m_rdata = OOR_VAL;
                m_mask = 32'hFFFF_FFFF;
            end
        end else if (wen != 4'h0) begin
            w = mem.exists(idx) ? mem[idx] : 32'h0;
            k = kn.exists(idx) ? kn[idx] : 4'h0;
            for (int i = 0; i < 4; i++)
                if (wen[i]) begin
                    w[8*i +: 8] = wdata[8*i +: 8];
                    k[i] = 1'b1;
                end
            mem[idx] = w;
            kn[idx] = k;
            m_wr = m_wr + 1;
        end else begin
            w = mem.exists(idx) ? mem[idx] : 32'h0;
            k = kn.exists(idx) ? kn[idx] : 4'h0;
            m_rdata = w;
            for (int i = 0; i < 4; i++) m_mask[8*i +: 8] = {8{k[i]}};
            m_rd = m_rd + 1;
        end
    endtask

    task automatic step(logic en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wdata);
        sram.en = en;
        sram.wen = wen;
        sram.addr = addr;
        sram.wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        model(en, wen, addr, wdata);
        chk("rdata", sram.rdata, m_rdata, m_mask);
        chk("err", {31'h0, err_o}, {31'h0, m_err});
        chk("err_addr", err_addr_o, m_err_addr);
        chk("rd_cnt", rd_cnt_o, m_rd);
        chk("wr_cnt", wr_cnt_o, m_wr);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_rdata"}, sram.rdata, 32'h0);
        chk({tag, "_err"}, {31'h0, err_o}, 32'h0);
        chk({tag, "_err_addr"}, err_addr_o, 32'h0);
        chk({tag, "_rd_cnt"}, rd_cnt_o, 32'h0);
        chk({tag, "_wr_cnt"}, wr_cnt_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sram.en = 1'b0;
        sram.wen = 4'h0;
        sram.addr = 32'h0;
        sram.wdata = 32'h0;
        m_rdata = 32'h0;
        m_mask = 32'hFFFF_FFFF;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        m_rd = 32'h0;
        m_wr = 32'h0;
        tv.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        tv.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'h2, 32'h0000_0020, 32'h0000_AA00, 32'hDEAD_BEEF});
        tv.push_back('{1'b1, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h1122_AA44});
        tv.push_back('{1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D, 32'h1122_AA44});
        tv.push_back('{1'b1, 4'h0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D});
        tv.push_back('{1'b1, 4'h0, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000});
        tv.push_back('{1'b1, 4'hF, 32'h0002_0000, 32'h1234_5678, 32'h0000_0000});
        tv.push_back('{1'b1, 4'hF, 32'h0000_0040, 32'h5555_AAAA, 32'h0000_0000});
        tv.push_back('{1'b1, 4'h8, 32'h0000_0040, 32'h7700_0000, 32'h0000_0000});
        tv.push_back('{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'h7755_AAAA});
        tv.push_back('{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h7755_AAAA});
        tv.push_back('{1'b1, 4'h0, 32'h0000_0023, 32'h0000_0000, 32'h1122_AA44});
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        foreach (tv[i]) begin
            step(tv[i].en, tv[i].wen, tv[i].addr, tv[i].wdata);
            chk($sformatf("tv%0d_rdata", i), sram.rdata, tv[i].exp);
        end
        chk("oor_err_addr_first", err_addr_o, 32'h0001_0000);

        // Reset lands the cycle after a write issues: the pending write must never reach the array
        sram.en = 1'b1;
        sram.wen = 4'hF;
        sram.addr = 32'h0000_0040;
        sram.wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        sram.en = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        m_rdata = 32'h0;
        m_mask = 32'hFFFF_FFFF;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        m_rd = 32'h0;
        m_wr = 32'h0;
        step(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        chk("rst_discard", sram.rdata, 32'h7755_AAAA);

        for (int n = 0; n < 400; n++) begin
            automatic logic [31:0] a = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            automatic logic en = $urandom_range(0, 3) != 0;
            automatic logic [3:0] wen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 24) == 0) a = a | (32'($urandom_range(1, 15)) << 16);
            step(en, wen, a, $urandom);
        end

        force dut.wr_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_o;
        m_wr = 32'hFFFF_FFFF;
        step(1'b1, 4'hF, 32'h0000_0104, 32'h0BAD_F00D);
        chk("wrap_first", wr_cnt_o, 32'h0000_0000);
        step(1'b1, 4'h3, 32'h0000_0108, 32'h0000_1234);
        chk("wrap_second", wr_cnt_o, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
